// File: rtl/mem_port_arbiter.sv
// N-port round-robin arbiter that serialises cache read/write requests onto one shared backing memory.
// Define MEM_ARB_FIXED_PRIO_EN to switch to fixed priority (lowest index wins, no rotating pointer).
module mem_port_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [N_PORTS-1:0]          req_read,
  input  logic [N_PORTS-1:0]          req_write,
  input  logic [N_PORTS*ADDR_W-1:0]   req_address,
  input  logic [N_PORTS*DATA_W-1:0]   req_writedata,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [N_PORTS-1:0]          req_busywait,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_writedata,
  input  logic [DATA_W-1:0]           mem_readdata,
  input  logic                        mem_busywait
);

  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [N_PORTS-1:0]  req_any;
  logic [GW-1:0]       base;
  logic [GW-1:0]       sel;
  logic [GW-1:0]       idx;
  logic [GW:0]         sum;
  logic                found;

  assign req_any = req_read | req_write;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [GW-1:0] ptr_q, ptr_d;

  // Pointer moves past the port just served so it becomes lowest priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == DONE) begin
      ptr_d = (grant_q == GW'(N_PORTS - 1)) ? '0 : grant_q + GW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign base = ptr_q;
`endif

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      sum = {1'b0, base} + (GW+1)'(k);
      if (sum >= (GW+1)'(N_PORTS)) sum = sum - (GW+1)'(N_PORTS);
      idx = sum[GW-1:0];
      if (!found && req_any[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ACCESS;
          grant_d = sel;
          op_wr_d = req_write[sel];
          addr_d  = req_address[sel*ADDR_W +: ADDR_W];
          wdata_d = req_writedata[sel*DATA_W +: DATA_W];
        end
      end
      ACCESS: begin
        if (!mem_busywait) begin
          if (!op_wr_q) rdata_d = mem_readdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode from state so an asynchronous reset drops them immediately.
  assign mem_read      = (state_q == ACCESS) & ~op_wr_q;
  assign mem_write     = (state_q == ACCESS) &  op_wr_q;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign req_readdata  = rdata_q;

  always_comb begin
    req_busywait = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      req_busywait[i] = req_any[i] & ~((state_q == DONE) && (grant_q == GW'(i)));
    end
  end

endmodule
